async_receiver: RTL and testbench

Serial RS-232 receive side of the FPGA-to-Raspberry-Pi link. Frame format is 8 data bits, LSB first, no parity, 1 stop bit checked; extra stop bits and idle time are accepted. The block oversamples the RxD line, rejects glitches, and delivers each byte with a one-cycle strobe. A framing-error strobe flags a bad stop bit. It is the partner of the existing transmitter and sits between the board RX pin and the command/data logic.

---
 rtl/async_receiver.sv | 177 +++++++++++++++++
 tb/tb_async_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/async_receiver.sv
// async_receiver: RS-232 receive side (8N1) of the FPGA-to-Pi link.
// Oversamples RxD with a fractional tick generator, removes glitches with a
// saturating 2-bit filter, and reports each byte or framing error as a
// one-cycle strobe.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for filtered line to go low
// START     | qualifying start bit, counting to mid-bit
// DATA      | sampling 8 data bits, one every OVERSAMPLING ticks
// STOP      | sampling the stop bit
// WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module async_receiver #(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 460800,
  parameter int unsigned OVERSAMPLING  = 8,
  parameter int unsigned ACC_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_busy
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLING);

  localparam logic [63:0] INC_WIDE =
    (((64'(BAUD) * 64'(OVERSAMPLING)) << ACC_WIDTH) + 64'(CLK_FREQUENCY / 2))
    / 64'(CLK_FREQUENCY);
  localparam logic [ACC_WIDTH-1:0] INC = INC_WIDE[ACC_WIDTH-1:0];

  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLING / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLING - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 tick;
  logic [1:0]           sync_q;
  logic [1:0]           fcnt_q, fcnt_d;
  logic                 filt_q, filt_d;
  logic [2:0]           state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  // The tick is the carry out of the free-running phase accumulator.
  assign {tick, acc_d} = {1'b0, acc_q} + {1'b0, INC};

  // Saturating filter with hysteresis: the line only flips at the count ends.
  always_comb begin
    fcnt_d = fcnt_q;
    filt_d = filt_q;
    if (tick) begin
      if (sync_q[1]) begin
        if (fcnt_q != 2'd3) fcnt_d = fcnt_q + 2'd1;
      end else if (fcnt_q != 2'd0) begin
        fcnt_d = fcnt_q - 2'd1;
      end
      if (fcnt_d == 2'd3)      filt_d = 1'b1;
      else if (fcnt_d == 2'd0) filt_d = 1'b0;
    end
  end

  // Frame FSM. It acts on the freshly updated filter value, so start detection
  // and bit sampling see the same filter latency and stay mid-bit aligned.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!filt_d) begin
            state_d  = START;
            os_cnt_d = '0;
          end
        end
        START: begin
          if (os_cnt_q == OS_HALF) begin
            if (filt_d) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              os_cnt_d  = '0;
              bit_cnt_d = 3'd0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        DATA: begin
          if (os_cnt_q == OS_LAST) begin
            shift_d   = {filt_d, shift_q[7:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        STOP: begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (filt_d) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (filt_d) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // All state registers, cleared asynchronously to idle-line values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sync_q    <= 2'b11;
      fcnt_q    <= 2'd3;
      filt_q    <= 1'b1;
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sync_q    <= {sync_q[0], RxD};
      fcnt_q    <= fcnt_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign RxD_frame_err  = ferr_q;
  assign RxD_busy       = busy_q;

endmodule

// File: tb/tb_async_receiver.sv
// Bench for async_receiver: 16 clk per bit, directed scenarios plus random
// frames, checked against a frame-level model of expected bytes and errors.
`timescale 1ns/1ps
module tb_async_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_frame_err;
  logic       RxD_busy;

  always #5 clk = ~clk;

  async_receiver #(
    .CLK_FREQUENCY(1_600_000),
    .BAUD         (100_000),
    .OVERSAMPLING (8),
    .ACC_WIDTH    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RxD           (RxD),
    .RxD_data      (RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_frame_err (RxD_frame_err),
    .RxD_busy      (RxD_busy)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // observed strobes
  logic [7:0]  rx_q[$];
  int unsigned rdy_t[$];
  int          ferr_seen = 0;
  int          both_seen = 0;
  int          wide_seen = 0;
  logic        prev_rdy = 1'b0;
  logic        prev_ferr = 1'b0;

  // reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_data;
  int          exp_ferr;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (RxD_data_ready) begin
        rx_q.push_back(RxD_data);
        rdy_t.push_back(cyc);
      end
      if (RxD_frame_err) ferr_seen++;
      if (RxD_data_ready && RxD_frame_err) both_seen++;
      if ((RxD_data_ready && prev_rdy) || (RxD_frame_err && prev_ferr)) wide_seen++;
      prev_rdy  = RxD_data_ready;
      prev_ferr = RxD_frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int clks);
    RxD = 1'b1;
    repeat (clks) @(negedge clk);
  endtask

  // Drives one frame; per4 is the bit period in quarter clocks so that
  // fractional baud mismatch can be generated.
  task automatic send_frame(input logic [7:0] b, input int per4, input int nstop,
                            input logic stop_val);
    int dur;
    for (int k = 0; k < 9 + nstop; k++) begin
      if (k == 0)      RxD = 1'b0;
      else if (k <= 8) RxD = b[k-1];
      else             RxD = stop_val;
      dur = ((k + 1) * per4) / 4 - (k * per4) / 4;
      repeat (dur) @(negedge clk);
    end
    if (stop_val) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] got;
    logic [7:0] want;
    check($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got  = rx_q.pop_front();
      want = exp_q.pop_front();
      check($sformatf("%s_byte", tag), got, want);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       seen;
    int         per4;
    int         ns;
    int         gap;

    rst      = 1'b1;
    RxD      = 1'b1;
    exp_data = 8'h00;
    exp_ferr = 0;
    repeat (3) @(negedge clk);
    check("rst_data", RxD_data, 8'h00);
    check("rst_ready", RxD_data_ready, 1'b0);
    check("rst_ferr", RxD_frame_err, 1'b0);
    check("rst_busy", RxD_busy, 1'b0);
    rst = 1'b0;
    idle(40);

    // loopback, two stop bits
    send_frame(8'h55, 64, 2, 1'b1);
    check("loop0_busy", RxD_busy, 1'b0);
    check("loop0_data", RxD_data, exp_data);
    send_frame(8'hA3, 64, 2, 1'b1);
    check("loop1_busy", RxD_busy, 1'b0);
    check("loop1_data", RxD_data, exp_data);
    idle(20);
    check_rx("loop");
    check("loop_ferr", ferr_seen, exp_ferr);

    // back-to-back, one stop bit, no gap
    rdy_t.delete();
    send_frame(8'h00, 64, 1, 1'b1);
    send_frame(8'hFF, 64, 1, 1'b1);
    send_frame(8'h81, 64, 1, 1'b1);
    idle(32);
    check("b2b_pulses", rdy_t.size(), 3);
    if (rdy_t.size() == 3) begin
      check("b2b_space0", rdy_t[1] - rdy_t[0], 160);
      check("b2b_space1", rdy_t[2] - rdy_t[1], 160);
    end
    check_rx("b2b");

    // short glitch is absorbed by the filter
    seen = 1'b0;
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RxD_busy) seen = 1'b1;
    end
    check("glitch4_busy_seen", seen, 1'b0);
    // longer glitch passes the filter but is rejected in START
    seen = 1'b0;
    RxD = 1'b0;
    repeat (8) @(negedge clk);
    RxD = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RxD_busy) seen = 1'b1;
    end
    check("glitch8_busy_seen", seen, 1'b1);
    check("glitch_busy", RxD_busy, 1'b0);
    check("glitch_data", RxD_data, exp_data);
    check("glitch_ferr", ferr_seen, exp_ferr);
    check_rx("glitch");

    // bad stop bit followed by a long break
    send_frame(8'hA5, 64, 1, 1'b0);
    RxD = 1'b0;
    repeat (20 * 16) @(negedge clk);
    check("break_ferr", ferr_seen, exp_ferr);
    check("break_busy", RxD_busy, 1'b1);
    check("break_data", RxD_data, exp_data);
    idle(32);
    check("break_busy_end", RxD_busy, 1'b0);
    send_frame(8'h3C, 64, 1, 1'b1);
    idle(32);
    check_rx("after_break");
    check("after_break_data", RxD_data, exp_data);
    check("after_break_ferr", ferr_seen, exp_ferr);

    // reset in the middle of bit 4 of 0x7E
    b = 8'h7E;
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = b[i];
      repeat (16) @(negedge clk);
    end
    RxD = b[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    exp_data = 8'h00;
    #1;
    check("midrst_data", RxD_data, exp_data);
    check("midrst_ready", RxD_data_ready, 1'b0);
    check("midrst_ferr", RxD_frame_err, 1'b0);
    check("midrst_busy", RxD_busy, 1'b0);
    @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(48);
    check_rx("midrst_drop");
    send_frame(8'h81, 64, 1, 1'b1);
    idle(32);
    check_rx("midrst_next");
    check("midrst_next_data", RxD_data, exp_data);

    // baud mismatch: 15 and 17 clk per bit, then 15.5 and 16.5
    send_frame(8'hF0, 60, 1, 1'b1);
    idle(32);
    send_frame(8'hF0, 68, 1, 1'b1);
    idle(32);
    send_frame(8'h0F, 62, 1, 1'b1);
    idle(32);
    send_frame(8'h0F, 66, 1, 1'b1);
    idle(32);
    check_rx("baud");
    check("baud_ferr", ferr_seen, exp_ferr);

    // random bytes, periods within about 3 percent, random stop bits and gaps
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom_range(0, 255));
      per4 = $urandom_range(62, 66);
      ns   = $urandom_range(1, 2);
      gap  = $urandom_range(0, 8);
      send_frame(b, per4, ns, 1'b1);
      idle(gap);
    end
    idle(40);
    check_rx("rand");
    check("rand_data", RxD_data, exp_data);
    check("rand_ferr", ferr_seen, exp_ferr);

    check("strobes_overlap", both_seen, 0);
    check("strobe_width", wide_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
